// File: rtl/data_path.sv
// Mini SRC single-bus 32-bit datapath: register file, special registers, ALU, CON logic and 512-word RAM.
// Define DATAPATH_EXT_MEM_EN to drop the internal RAM; Read+MDRin then loads MDR from Mdatain.
module data_path #(
    parameter int MEM_DEPTH = 512,
    parameter int WIDTH     = 32,
    localparam int AW       = $clog2(MEM_DEPTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             PCout,
    input  logic             Zhighout,
    input  logic             Zlowout,
    input  logic             MDRout,
    input  logic             HIout,
    input  logic             LOout,
    input  logic             Yout,
    input  logic             InPortout,
    input  logic             Cout,
    input  logic             Rout,
    input  logic             BAout,
    input  logic             MARin,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             ZHighIn,
    input  logic             ZLowIn,
    input  logic             CONin,
    input  logic             OutPortin,
    input  logic             Rin,
    input  logic             IncPC,
    input  logic             Read,
    input  logic             Write,
    input  logic             Gra,
    input  logic             Grb,
    input  logic             Grc,
    input  logic [4:0]       opcode,
    input  logic [AW-1:0]    Address,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic [WIDTH-1:0] InPortData,
    output logic             R0out,
    output logic             R1out,
    output logic             R2out,
    output logic             R3out,
    output logic             R4out,
    output logic             R5out,
    output logic             R6out,
    output logic             R7out,
    output logic             R8out,
    output logic             R9out,
    output logic             R10out,
    output logic             R11out,
    output logic             R12out,
    output logic             R13out,
    output logic             R14out,
    output logic             R15out,
    output logic             CON_out,
    output logic [WIDTH-1:0] OutPortData
);
    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0] rf_q [16];
    logic [WIDTH-1:0] pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q;
    logic [WIDTH-1:0] zhi_q, zlo_q, inport_q, outport_q;
    logic             con_q;

    logic [3:0]       sel;
    logic [15:0]      r_en;
    logic [WIDTH-1:0] c_ext, bus, mem_rd, mdr_d;
    logic [WIDTH-1:0] alu_lo, alu_hi;
    logic             con_d;

    // Select-and-encode: enabled IR fields are ORed into one register index.
    always_comb begin
        sel  = ({4{Gra}} & ir_q[26:23]) | ({4{Grb}} & ir_q[22:19]) | ({4{Grc}} & ir_q[18:15]);
        r_en = (Rout || BAout) ? (16'b1 << sel) : 16'b0;
    end

    assign {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
            R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out} = r_en;

    assign c_ext = {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]};

    always_comb begin
        bus = '0;
        if (r_en != 16'b0) begin
            // BAout on R0 yields a zero base instead of the register contents.
            bus = (BAout && sel == 4'd0) ? '0 : rf_q[sel];
        end else if (HIout)     bus = hi_q;
        else if (LOout)         bus = lo_q;
        else if (Zhighout)      bus = zhi_q;
        else if (Zlowout)       bus = zlo_q;
        else if (PCout)         bus = pc_q;
        else if (MDRout)        bus = mdr_q;
        else if (InPortout)     bus = inport_q;
        else if (Cout)          bus = c_ext;
        else if (Yout)          bus = y_q;
    end

    logic [WIDTH-1:0]          a, b;
    logic [SW-1:0]             sh;
    logic [2*WIDTH-1:0]        rot_r, rot_l;
    logic signed [2*WIDTH-1:0] prod;

    assign a  = y_q;
    assign b  = bus;
    assign sh = b[SW-1:0];

    always_comb begin
        alu_lo = b;
        alu_hi = '0;
        rot_r  = {a, a} >> sh;
        rot_l  = {a, a} << sh;
        prod   = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        case (opcode)
            5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01100: alu_lo = a + b;
            5'b00100:           alu_lo = a - b;
            5'b00101, 5'b01101: alu_lo = a & b;
            5'b00110, 5'b01110: alu_lo = a | b;
            5'b00111:           alu_lo = rot_r[WIDTH-1:0];
            5'b01000:           alu_lo = rot_l[2*WIDTH-1:WIDTH];
            5'b01001:           alu_lo = a >> sh;
            5'b01010:           alu_lo = $signed(a) >>> sh;
            5'b01011:           alu_lo = a << sh;
            5'b01111: begin
                if (b == '0) begin
                    alu_lo = '1;
                    alu_hi = a;
                end else if (a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1) begin
                    // Most-negative / -1 overflows; keep the wrapped quotient.
                    alu_lo = a;
                    alu_hi = '0;
                end else begin
                    alu_lo = $signed(a) / $signed(b);
                    alu_hi = $signed(a) % $signed(b);
                end
            end
            5'b10000: begin
                alu_lo = prod[WIDTH-1:0];
                alu_hi = prod[2*WIDTH-1:WIDTH];
            end
            5'b10001: alu_lo = '0 - b;
            5'b10010: alu_lo = ~b;
            default:  alu_lo = b;
        endcase
        if (IncPC) begin
            alu_lo = b + WIDTH'(1);
            alu_hi = '0;
        end
    end

    always_comb begin
        case (ir_q[20:19])
            2'b00:   con_d = (bus == '0);
            2'b01:   con_d = (bus != '0);
            2'b10:   con_d = !bus[WIDTH-1] && (bus != '0);
            default: con_d = bus[WIDTH-1];
        endcase
    end

`ifndef DATAPATH_EXT_MEM_EN
    logic [WIDTH-1:0] mem [MEM_DEPTH];

    // Preload only while clear is held; the RAM itself is never reset.
    always_ff @(posedge clock) begin
        if (clear) begin
            mem[Address] <= Mdatain;
        end else if (Write) begin
            mem[mar_q[AW-1:0]] <= mdr_q;
        end
    end

    assign mem_rd = mem[mar_q[AW-1:0]];

    logic unused_bits;
    assign unused_bits = ^{mar_q[WIDTH-1:AW], ir_q[WIDTH-1:27]};
`else
    assign mem_rd = Mdatain;

    logic unused_bits;
    assign unused_bits = ^{Address, Write, mar_q, ir_q[WIDTH-1:27]};
`endif

    assign mdr_d = Read ? mem_rd : bus;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
            pc_q      <= '0;
            ir_q      <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            y_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            zhi_q     <= '0;
            zlo_q     <= '0;
            inport_q  <= '0;
            outport_q <= '0;
            con_q     <= 1'b0;
        end else begin
            inport_q <= InPortData;
            if (Rin)       rf_q[sel] <= bus;
            if (PCin)      pc_q      <= bus;
            if (IRin)      ir_q      <= bus;
            if (MARin)     mar_q     <= bus;
            if (MDRin)     mdr_q     <= mdr_d;
            if (Yin)       y_q       <= bus;
            if (HIin)      hi_q      <= bus;
            if (LOin)      lo_q      <= bus;
            if (ZHighIn)   zhi_q     <= alu_hi;
            if (ZLowIn)    zlo_q     <= alu_lo;
            if (OutPortin) outport_q <= bus;
            if (CONin)     con_q     <= con_d;
        end
    end

    assign CON_out     = con_q;
    assign OutPortData = outport_q;

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: fetch/load sequences, ALU vector table and CON table,
// with register contents observed by routing them through the bus into OutPort.
module tb_data_path;
    logic        clock = 1'b0;
    logic        clear;
    logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout, InPortout, Cout;
    logic        Rout, BAout;
    logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, CONin, OutPortin, Rin;
    logic        IncPC, Read, Write, Gra, Grb, Grc;
    logic [4:0]  opcode;
    logic [8:0]  Address;
    logic [31:0] Mdatain, InPortData;
    logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
    logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out;
    logic        CON_out;
    logic [31:0] OutPortData;
    logic [15:0] r_outs;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } alu_vec_t;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] busv;
        logic [31:0] con;
    } con_vec_t;

    alu_vec_t alu_tab[19];
    con_vec_t con_tab[9];

    always #5 clock = ~clock;

    assign r_outs = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                     R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

    data_path dut (
        .clock(clock), .clear(clear),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Yout(Yout), .InPortout(InPortout), .Cout(Cout),
        .Rout(Rout), .BAout(BAout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin),
        .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .CONin(CONin), .OutPortin(OutPortin),
        .Rin(Rin), .IncPC(IncPC), .Read(Read), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .opcode(opcode),
        .Address(Address), .Mdatain(Mdatain), .InPortData(InPortData),
        .R0out(R0out), .R1out(R1out), .R2out(R2out), .R3out(R3out),
        .R4out(R4out), .R5out(R5out), .R6out(R6out), .R7out(R7out),
        .R8out(R8out), .R9out(R9out), .R10out(R10out), .R11out(R11out),
        .R12out(R12out), .R13out(R13out), .R14out(R14out), .R15out(R15out),
        .CON_out(CON_out), .OutPortData(OutPortData)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_ctrl();
        {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout, InPortout, Cout} = '0;
        {Rout, BAout} = '0;
        {MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, CONin, OutPortin, Rin} = '0;
        {IncPC, Read, Write, Gra, Grb, Grc} = '0;
        opcode = 5'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Caller selects the bus source; this latches the bus into OutPort and scores it.
    task automatic port_cmp(input string nm);
        logic [31:0] e;
        OutPortin = 1'b1;
        tick();
        clr_ctrl();
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard queue empty", nm);
        end else begin
            e = exp_q.pop_front();
            chk(nm, OutPortData, e);
        end
    endtask

    task automatic port_check(input string nm, input logic [31:0] exp);
        exp_q.push_back(exp);
        port_cmp(nm);
    endtask

    task automatic put_inport(input logic [31:0] v);
        InPortData = v;
        tick();
    endtask

    initial begin
        alu_tab[0]  = '{5'b00011, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0};
        alu_tab[1]  = '{5'b01100, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h0};
        alu_tab[2]  = '{5'b00100, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0};
        alu_tab[3]  = '{5'b00101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0};
        alu_tab[4]  = '{5'b01110, 32'hF0F0F0F0, 32'h0F000000, 32'hFFF0F0F0, 32'h0};
        alu_tab[5]  = '{5'b00111, 32'h80000001, 32'h00000001, 32'hC0000000, 32'h0};
        alu_tab[6]  = '{5'b00111, 32'h0000000F, 32'h00000024, 32'hF0000000, 32'h0};
        alu_tab[7]  = '{5'b01000, 32'h80000001, 32'h00000004, 32'h00000018, 32'h0};
        alu_tab[8]  = '{5'b01001, 32'h80000001, 32'h00000001, 32'h40000000, 32'h0};
        alu_tab[9]  = '{5'b01010, 32'h80000001, 32'h00000001, 32'hC0000000, 32'h0};
        alu_tab[10] = '{5'b01011, 32'h80000001, 32'h00000001, 32'h00000002, 32'h0};
        alu_tab[11] = '{5'b01111, 32'h00000011, 32'h00000005, 32'h00000003, 32'h00000002};
        alu_tab[12] = '{5'b01111, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678};
        alu_tab[13] = '{5'b01111, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF};
        alu_tab[14] = '{5'b10000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 32'hFFFFFFFF};
        alu_tab[15] = '{5'b10000, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001};
        alu_tab[16] = '{5'b10001, 32'h12345678, 32'h00000005, 32'hFFFFFFFB, 32'h0};
        alu_tab[17] = '{5'b10010, 32'h12345678, 32'h0000FFFF, 32'hFFFF0000, 32'h0};
        alu_tab[18] = '{5'b11111, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};

        con_tab[0] = '{32'h00080000, 32'h00000000, 32'd0};
        con_tab[1] = '{32'h00080000, 32'h00000005, 32'd1};
        con_tab[2] = '{32'h00180000, 32'h80000000, 32'd1};
        con_tab[3] = '{32'h00180000, 32'h00000005, 32'd0};
        con_tab[4] = '{32'h00100000, 32'h80000000, 32'd0};
        con_tab[5] = '{32'h00100000, 32'h00000005, 32'd1};
        con_tab[6] = '{32'h00000000, 32'h00000000, 32'd1};
        con_tab[7] = '{32'h00000000, 32'h00000007, 32'd0};
        con_tab[8] = '{32'h00080000, 32'h00000003, 32'd1};

        clr_ctrl();
        clear      = 1'b1;
        InPortData = '0;
        Address    = 9'h000;
        Mdatain    = 32'h01000095;
        tick();
        Address = 9'h095;
        Mdatain = 32'h00001234;
        tick();
        chk("rst_outport", OutPortData, 32'h0);
        chk("rst_con", {31'b0, CON_out}, 32'h0);
        chk("rst_rdec", {16'b0, r_outs}, 32'h0);
        clear = 1'b0;
        tick();

        // R0 gets a nonzero value so BAout's forced zero is distinguishable.
        put_inport(32'h00000077);
        InPortout = 1; Gra = 1; Rin = 1; tick(); clr_ctrl();

        PCout = 1; MARin = 1; IncPC = 1; ZLowIn = 1; tick(); clr_ctrl();
        Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; tick(); clr_ctrl();
        MDRout = 1; IRin = 1; tick(); clr_ctrl();

        PCout = 1;  port_check("fetch_pc", 32'h1);
        Cout = 1;   port_check("fetch_c", 32'h95);
        MDRout = 1; port_check("fetch_mdr", 32'h01000095);
        Gra = 1; Rout = 1; #1;
        chk("fetch_ra_dec", {16'b0, r_outs}, 32'h0004);
        port_check("r2_before", 32'h0);

        Grb = 1; BAout = 1; Yin = 1; #1;
        chk("ba_dec", {16'b0, r_outs}, 32'h0001);
        tick(); clr_ctrl();
        Yout = 1; port_check("t3_y", 32'h0);
        Cout = 1; opcode = 5'b00011; ZLowIn = 1; tick(); clr_ctrl();
        Zlowout = 1; port_check("t4_z", 32'h95);
        Zlowout = 1; MARin = 1; tick(); clr_ctrl();
        Read = 1; MDRin = 1; tick(); clr_ctrl();
        Gra = 1; MDRout = 1; Rin = 1; tick(); clr_ctrl();
        Gra = 1; Rout = 1; port_check("ld_r2", 32'h00001234);
        Grb = 1; Rout = 1; port_check("r0_kept", 32'h00000077);

        // Write and read together: RAM takes the new MDR, MDR takes the old RAM word.
        put_inport(32'h0000CAFE);
        InPortout = 1; MDRin = 1; tick(); clr_ctrl();
        Read = 1; Write = 1; MDRin = 1; tick(); clr_ctrl();
        MDRout = 1; port_check("rw_old", 32'h00001234);
        Read = 1; MDRin = 1; tick(); clr_ctrl();
        MDRout = 1; port_check("rw_new", 32'h0000CAFE);

        put_inport(32'h00005A5A);
        InPortout = 1; HIin = 1; tick(); clr_ctrl();
        put_inport(32'h0000A5A5);
        InPortout = 1; LOin = 1; tick(); clr_ctrl();
        HIout = 1; port_check("hi_reg", 32'h00005A5A);
        LOout = 1; port_check("lo_reg", 32'h0000A5A5);

        for (int i = 0; i < 19; i++) begin
            put_inport(alu_tab[i].a);
            InPortout = 1; Yin = 1; tick(); clr_ctrl();
            put_inport(alu_tab[i].b);
            InPortout = 1; opcode = alu_tab[i].op; ZLowIn = 1; ZHighIn = 1;
            exp_q.push_back(alu_tab[i].lo);
            exp_q.push_back(alu_tab[i].hi);
            tick(); clr_ctrl();
            Zlowout = 1;  port_cmp($sformatf("alu%0d_lo", i));
            Zhighout = 1; port_cmp($sformatf("alu%0d_hi", i));
        end

        for (int i = 0; i < 9; i++) begin
            put_inport(con_tab[i].ir);
            InPortout = 1; IRin = 1; tick(); clr_ctrl();
            put_inport(con_tab[i].busv);
            InPortout = 1; CONin = 1;
            exp_q.push_back(con_tab[i].con);
            tick(); clr_ctrl();
            chk($sformatf("con%0d", i), {31'b0, CON_out}, exp_q.pop_front());
        end

        put_inport(32'h0000ABCD);
        InPortout = 1; port_check("outport", 32'h0000ABCD);
        port_check("bus_idle", 32'h0);
        put_inport(32'h0000ABCD);
        InPortout = 1; port_check("outport2", 32'h0000ABCD);

        // Asynchronous clear mid-cycle: outputs drop before any clock edge.
        #2;
        clear = 1'b1;
        #1;
        chk("clr_outport", OutPortData, 32'h0);
        chk("clr_con", {31'b0, CON_out}, 32'h0);
        tick();
        clear = 1'b0;
        tick();
        PCout = 1;   port_check("clr_pc", 32'h0);
        Yout = 1;    port_check("clr_y", 32'h0);
        Zlowout = 1; port_check("clr_z", 32'h0);
        Grb = 1; Rout = 1; port_check("clr_r0", 32'h0);
        Read = 1; MDRin = 1; tick(); clr_ctrl();
        MDRout = 1;  port_check("ram_kept", 32'h01000095);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
